// File: rtl/robo_navegador.sv
// Robot navigator: tracks heading and grid position, sequences turn/advance
// commands over a valid/ready handshake and drives the motor action code.
module robo_navegador #(
    parameter int COORD_W     = 4,
    parameter int GRID_X      = 16,
    parameter int GRID_Y      = 16,
    parameter int MOVE_CYCLES = 4,
    parameter int X0          = 0,
    parameter int Y0          = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd,
    input  logic               obstaculo,
    output logic [2:0]         orientacao,
    output logic [2:0]         acao,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               busy,
    output logic               done,
    output logic               bloqueado
);

    localparam logic [2:0] NORTE = 3'b001;
    localparam logic [2:0] OESTE = 3'b010;
    localparam logic [2:0] LESTE = 3'b011;
    localparam logic [2:0] SUL   = 3'b100;

    localparam int CNT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_Y - 1);
    localparam logic [COORD_W-1:0] X_RST    = COORD_W'(X0);
    localparam logic [COORD_W-1:0] Y_RST    = COORD_W'(Y0);
    localparam logic [COORD_W-1:0] UM       = COORD_W'(1);

    typedef enum logic [1:0] {OCIOSO, AVANCANDO, FIM} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   contador;
    logic               recusado;
    logic               aceite;
    logic               avanco_livre;
    logic               ultimo_passo;

    function automatic logic [2:0] vira_esquerda(input logic [2:0] h);
        case (h)
            NORTE:   return OESTE;
            OESTE:   return SUL;
            SUL:     return LESTE;
            LESTE:   return NORTE;
            default: return NORTE;
        endcase
    endfunction

    function automatic logic [2:0] vira_direita(input logic [2:0] h);
        case (h)
            NORTE:   return LESTE;
            LESTE:   return SUL;
            SUL:     return OESTE;
            OESTE:   return NORTE;
            default: return NORTE;
        endcase
    endfunction

    assign aceite       = cmd_valid && (state == OCIOSO);
    assign ultimo_passo = (contador == CNT_LAST);

    // An advance is refused at the grid edge or when the cell ahead is blocked.
    always_comb begin
        avanco_livre = 1'b0;
        case (orientacao)
            NORTE:   avanco_livre = (pos_y != Y_MAX);
            SUL:     avanco_livre = (pos_y != '0);
            LESTE:   avanco_livre = (pos_x != X_MAX);
            OESTE:   avanco_livre = (pos_x != '0);
            default: avanco_livre = 1'b0;
        endcase
        if (obstaculo)
            avanco_livre = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= OCIOSO;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OCIOSO: begin
                if (aceite) begin
                    case (cmd)
                        2'b01, 2'b10: state_next = FIM;
                        2'b11:        state_next = avanco_livre ? AVANCANDO : FIM;
                        default:      state_next = OCIOSO;
                    endcase
                end
            end
            AVANCANDO: if (ultimo_passo) state_next = FIM;
            FIM:       state_next = OCIOSO;
            default:   state_next = OCIOSO;
        endcase
    end

    // Heading changes only on turn accepts; position only at the last move step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            orientacao <= NORTE;
            pos_x      <= X_RST;
            pos_y      <= Y_RST;
            contador   <= '0;
            recusado   <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (aceite) begin
                        recusado <= (cmd == 2'b11) && !avanco_livre;
                        contador <= '0;
                        if (cmd == 2'b01)
                            orientacao <= vira_esquerda(orientacao);
                        else if (cmd == 2'b10)
                            orientacao <= vira_direita(orientacao);
                    end
                end
                AVANCANDO: begin
                    contador <= contador + 1'b1;
                    if (ultimo_passo) begin
                        case (orientacao)
                            NORTE:   pos_y <= pos_y + UM;
                            SUL:     pos_y <= pos_y - UM;
                            LESTE:   pos_x <= pos_x + UM;
                            OESTE:   pos_x <= pos_x - UM;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state == OCIOSO);
        busy      = (state != OCIOSO);
        done      = (state == FIM);
        bloqueado = (state == FIM) && recusado;
        acao      = (state == AVANCANDO) ? orientacao : 3'b000;
    end

endmodule
